// File: rtl/calc_pkg.sv
// Shared types and default divide ratios for the calculator timebase.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } tick_state_t;

    localparam int DIV_10M = 5;
    localparam int DIV_1M  = 10;
    localparam int DIV_1K  = 1000;
    localparam int DIV_1HZ = 1000;

endpackage

// File: rtl/tick_scheduler_prescale.sv
// One divide-by-DIV prescaler stage. It emits a one-cycle tick on the
// enabled cycle in which its count wraps.
module prescale_stage
    import calc_pkg::*;
#(
    parameter int DIV = DIV_10M
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Combinational, so that a whole cascade of wraps lands in a single cycle.
    assign tick = en & ~clear & (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/tick_scheduler.sv
// Timebase: four cascaded prescalers generating enable strobes, plus a
// request/acknowledge interval timer that counts down on the 1 Hz strobe.
module tick_scheduler
    import calc_pkg::*;
#(
    parameter int DIV0  = DIV_10M,
    parameter int DIV1  = DIV_1M,
    parameter int DIV2  = DIV_1K,
    parameter int DIV3  = DIV_1HZ,
    parameter int TMR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    output logic             tick_10m,
    output logic             tick_1m,
    output logic             tick_1k,
    output logic             tick_1hz,
    input  logic             timer_req,
    input  logic [TMR_W-1:0] timer_secs,
    output logic             timer_ack,
    output logic             timer_busy,
    output logic             timer_done,
    output logic [TMR_W-1:0] timer_left
);
    localparam int STAGES = 4;

    function automatic int divOf(input int idx);
        case (idx)
            0:       return DIV0;
            1:       return DIV1;
            2:       return DIV2;
            default: return DIV3;
        endcase
    endfunction

    logic [STAGES:0]   stageEn;
    logic [STAGES-1:0] stageTick;

    assign stageEn[0] = run & ~clear;

    for (genvar g = 0; g < STAGES; g++) begin : gStage
        prescale_stage #(.DIV(divOf(g))) uStage (
            .clock (clock),
            .reset (reset),
            .clear (clear),
            .en    (stageEn[g]),
            .tick  (stageTick[g])
        );
        assign stageEn[g+1] = stageTick[g];
    end

    assign tick_10m = stageTick[0];
    assign tick_1m  = stageTick[1];
    assign tick_1k  = stageTick[2];
    assign tick_1hz = stageTick[3];

    tick_state_t      state;
    logic             ackQ;
    logic             doneQ;
    logic [TMR_W-1:0] leftQ;

    // A zero-length arm enters DONE alongside the ack, so DONE lingers one
    // extra cycle there to keep the done pulse after the ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            leftQ <= '0;
            ackQ  <= 1'b0;
            doneQ <= 1'b0;
        end else begin
            ackQ  <= 1'b0;
            doneQ <= 1'b0;
            if (clear) begin
                state <= IDLE;
                leftQ <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (timer_req) begin
                            leftQ <= timer_secs;
                            ackQ  <= 1'b1;
                            state <= (timer_secs == '0) ? DONE : COUNT;
                        end
                    end
                    COUNT: begin
                        if (tick_1hz) begin
                            if (leftQ != '0)
                                leftQ <= leftQ - 1'b1;
                            if (leftQ <= TMR_W'(1)) begin
                                state <= DONE;
                                doneQ <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (doneQ)
                            state <= IDLE;
                        else
                            doneQ <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign timer_ack  = ackQ;
    assign timer_done = doneQ;
    assign timer_busy = (state == COUNT);
    assign timer_left = leftQ;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler with small divide ratios (24-cycle 1 Hz).
module tb_tick_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic       timer_req = 1'b0;
    logic [7:0] timer_secs = 8'd0;
    logic       tick_10m, tick_1m, tick_1k, tick_1hz;
    logic       timer_ack, timer_busy, timer_done;
    logic [7:0] timer_left;

    tick_scheduler #(.DIV0(2), .DIV1(2), .DIV2(3), .DIV3(2), .TMR_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .tick_10m   (tick_10m),
        .tick_1m    (tick_1m),
        .tick_1k    (tick_1k),
        .tick_1hz   (tick_1hz),
        .timer_req  (timer_req),
        .timer_secs (timer_secs),
        .timer_ack  (timer_ack),
        .timer_busy (timer_busy),
        .timer_done (timer_done),
        .timer_left (timer_left)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] ticks;
        logic       ack;
        logic       busy;
        logic       done;
        logic [7:0] left;
    } exp_t;

    exp_t expQ[$];
    exp_t mon;

    // reference model state: enabled-cycle count since reset/clear, timer phase
    int         mCnt;
    int         mState;
    logic [7:0] mLeft;
    logic       mAck;
    logic       mDone;

    int cycleNum = 0;
    int hzFirst = 0;
    int hzCount = 0;

    task automatic mdlReset();
        mCnt = 0; mState = 0; mLeft = 8'd0; mAck = 1'b0; mDone = 1'b0;
    endtask

    task automatic step(input logic r, input logic c, input logic q, input logic [7:0] s);
        exp_t e;
        logic en, hz, nd;
        @(posedge clock); #1;
        run = r; clear = c; timer_req = q; timer_secs = s;
        cycleNum++;
        en = r && !c;
        e.ticks[0] = en && (mCnt % 2 == 1);
        e.ticks[1] = en && (mCnt % 4 == 3);
        e.ticks[2] = en && (mCnt % 12 == 11);
        e.ticks[3] = en && (mCnt % 24 == 23);
        hz = e.ticks[3];
        e.ack = mAck; e.busy = (mState == 1); e.done = mDone; e.left = mLeft;
        expQ.push_back(e);
        mAck = 1'b0; nd = 1'b0;
        if (c) begin
            mCnt = 0; mState = 0; mLeft = 8'd0;
        end else begin
            if (r) mCnt = (mCnt + 1) % 24;
            case (mState)
                0: if (q) begin mLeft = s; mAck = 1'b1; mState = (s == 8'd0) ? 2 : 1; end
                1: if (hz) begin
                       if (mLeft == 8'd1) begin mState = 2; nd = 1'b1; end
                       mLeft = mLeft - 8'd1;
                   end
                default: if (mDone) mState = 0; else nd = 1'b1;
            endcase
        end
        mDone = nd;
    endtask

    always @(negedge clock) begin
        if (tick_1hz) begin
            hzCount++;
            if (hzFirst == 0) hzFirst = cycleNum;
        end
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            chk("ticks", {28'd0, tick_1hz, tick_1k, tick_1m, tick_10m}, {28'd0, mon.ticks});
            chk("ack", {31'd0, timer_ack}, {31'd0, mon.ack});
            chk("busy", {31'd0, timer_busy}, {31'd0, mon.busy});
            chk("done", {31'd0, timer_done}, {31'd0, mon.done});
            chk("left", {24'd0, timer_left}, {24'd0, mon.left});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] seqWord;
        logic [7:0]  prevLeft;
        logic        got;
        mdlReset();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ticks", {28'd0, tick_1hz, tick_1k, tick_1m, tick_10m}, 32'd0);
        chk("rst_ack", {31'd0, timer_ack}, 32'd0);
        chk("rst_busy", {31'd0, timer_busy}, 32'd0);
        chk("rst_done", {31'd0, timer_done}, 32'd0);
        chk("rst_left", {24'd0, timer_left}, 32'd0);
        @(negedge clock); #2 reset = 1'b1;

        // cadence
        cycleNum = 0; hzFirst = 0; hzCount = 0;
        repeat (48) step(1'b1, 1'b0, 1'b0, 8'd0);
        @(negedge clock); #1;
        chk("cad_first", hzFirst, 32'd24);
        chk("cad_count", hzCount, 32'd2);

        // freeze
        step(1'b1, 1'b1, 1'b0, 8'd0);
        cycleNum = 0; hzFirst = 0;
        for (int i = 1; i <= 34; i++) step((i >= 10 && i <= 16) ? 1'b0 : 1'b1, 1'b0, 1'b0, 8'd0);
        @(negedge clock); #1;
        chk("frz_first", hzFirst, 32'd31);

        // 3 second timer
        step(1'b1, 1'b0, 1'b1, 8'd3);
        step(1'b1, 1'b0, 1'b0, 8'd0); #3;
        chk("t3_ack", {31'd0, timer_ack}, 32'd1);
        chk("t3_busy", {31'd0, timer_busy}, 32'd1);
        chk("t3_left", {24'd0, timer_left}, 32'd3);
        seqWord = 32'd3; prevLeft = 8'd3; got = 1'b0;
        for (int i = 0; i < 120 && !got; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'd0); #3;
            if (timer_left != prevLeft) begin
                seqWord = (seqWord << 8) | {24'd0, timer_left};
                prevLeft = timer_left;
            end
            if (timer_done) got = 1'b1;
        end
        chk("t3_done", {31'd0, got}, 32'd1);
        chk("t3_seq", seqWord, 32'h03020100);
        step(1'b1, 1'b0, 1'b0, 8'd0); #3;
        chk("t3_idle", {31'd0, timer_busy}, 32'd0);

        // zero-length interval
        step(1'b1, 1'b0, 1'b1, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0); #3;
        chk("z_ack", {31'd0, timer_ack}, 32'd1);
        chk("z_busy", {31'd0, timer_busy}, 32'd0);
        chk("z_early", {31'd0, timer_done}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0); #3;
        chk("z_done", {31'd0, timer_done}, 32'd1);
        chk("z_busy2", {31'd0, timer_busy}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0);

        // arm while frozen, then an ignored request during COUNT
        step(1'b0, 1'b0, 1'b1, 8'd5);
        step(1'b0, 1'b0, 1'b0, 8'd0); #3;
        chk("ign_arm", {31'd0, timer_ack}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'd9);
        step(1'b0, 1'b0, 1'b0, 8'd0); #3;
        chk("ign_ack", {31'd0, timer_ack}, 32'd0);
        chk("ign_left", {24'd0, timer_left}, 32'd5);
        chk("ign_busy", {31'd0, timer_busy}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'd0);

        // clear together with a request
        step(1'b1, 1'b1, 1'b1, 8'd4);
        step(1'b1, 1'b0, 1'b0, 8'd0); #3;
        chk("cr_ack", {31'd0, timer_ack}, 32'd0);
        chk("cr_busy", {31'd0, timer_busy}, 32'd0);
        chk("cr_left", {24'd0, timer_left}, 32'd0);

        // clear mid-count
        step(1'b1, 1'b0, 1'b1, 8'd3);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'd0); #3;
            if (timer_left == 8'd2) got = 1'b1;
        end
        chk("cm_reach2", {31'd0, got}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0); #3;
        chk("cm_left", {24'd0, timer_left}, 32'd0);
        chk("cm_busy", {31'd0, timer_busy}, 32'd0);
        repeat (30) step(1'b1, 1'b0, 1'b0, 8'd0);

        // async reset mid-count
        step(1'b1, 1'b0, 1'b1, 8'd5);
        repeat (10) step(1'b1, 1'b0, 1'b0, 8'd0);
        @(negedge clock); #2;
        reset = 1'b0; run = 1'b0; timer_req = 1'b0; clear = 1'b0;
        #1;
        chk("ar_ticks", {28'd0, tick_1hz, tick_1k, tick_1m, tick_10m}, 32'd0);
        chk("ar_ack", {31'd0, timer_ack}, 32'd0);
        chk("ar_busy", {31'd0, timer_busy}, 32'd0);
        chk("ar_done", {31'd0, timer_done}, 32'd0);
        chk("ar_left", {24'd0, timer_left}, 32'd0);
        mdlReset();
        @(negedge clock); #2 reset = 1'b1;
        cycleNum = 0; hzFirst = 0;
        repeat (26) step(1'b1, 1'b0, 1'b0, 8'd0);
        @(negedge clock); #1;
        chk("ar_first", hzFirst, 32'd24);

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
